// File: rtl/wb_regfile.sv
// Write-back pipe (EX->MEM->WB, 2 cycles) feeding a 32-entry register file with two forwarding read ports.
// stall freezes MEM/WB and allows one commit per WB occupancy; flush squashes the slot entering MEM.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ex_w_addr,
    input  logic [DATA_W-1:0] ex_w_data,
    input  logic              ex_w_en,
    input  logic              stall,
    input  logic              flush,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    output logic [ADDR_W-1:0] wb_w_addr,
    output logic [DATA_W-1:0] wb_w_data,
    output logic              wb_w_en
);

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_en;
    logic              r_wb_pend;
    logic [DATA_W-1:0] r_rf [NREG];

    logic              w_commit;

    assign w_commit = r_wb_en && r_wb_pend && (r_wb_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_en   <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wb_en    <= 1'b0;
            r_wb_pend  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_commit) begin
                r_rf[r_wb_addr] <= r_wb_data;
            end
            if (!stall) begin
                if (flush) begin
                    r_mem_addr <= '0;
                    r_mem_data <= '0;
                    r_mem_en   <= 1'b0;
                end else begin
                    r_mem_addr <= ex_w_addr;
                    r_mem_data <= ex_w_data;
                    r_mem_en   <= ex_w_en;
                end
                r_wb_addr <= r_mem_addr;
                r_wb_data <= r_mem_data;
                r_wb_en   <= r_mem_en;
                r_wb_pend <= 1'b1;
            end else begin
                // Any pending write has just committed (or was to r0); a held WB must not write again.
                r_wb_pend <= 1'b0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic en, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!rst_n || !en || addr == '0) begin
            v = '0;
        end else if (ex_w_en && ex_w_addr == addr) begin
            v = ex_w_data;
        end else if (r_mem_en && r_mem_addr == addr) begin
            v = r_mem_data;
        end else if (r_wb_en && r_wb_addr == addr) begin
            v = r_wb_data;
        end else begin
            v = r_rf[addr];
        end
        return v;
    endfunction

    always_comb begin
        rd1_data = f_read(rd1_en, rd1_addr);
        rd2_data = f_read(rd2_en, rd2_addr);
    end

    assign wb_w_addr = r_wb_addr;
    assign wb_w_data = r_wb_data;
    assign wb_w_en   = r_wb_en;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: inputs change 1 time unit after each rising edge, outputs checked before the next edge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ex_w_addr;
    logic [31:0] ex_w_data;
    logic        ex_w_en;
    logic        stall;
    logic        flush;
    logic        rd1_en;
    logic [4:0]  rd1_addr;
    logic [31:0] rd1_data;
    logic        rd2_en;
    logic [4:0]  rd2_addr;
    logic [31:0] rd2_data;
    logic [4:0]  wb_w_addr;
    logic [31:0] wb_w_data;
    logic        wb_w_en;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_w_addr (ex_w_addr),
        .ex_w_data (ex_w_data),
        .ex_w_en   (ex_w_en),
        .stall     (stall),
        .flush     (flush),
        .rd1_en    (rd1_en),
        .rd1_addr  (rd1_addr),
        .rd1_data  (rd1_data),
        .rd2_en    (rd2_en),
        .rd2_addr  (rd2_addr),
        .rd2_data  (rd2_data),
        .wb_w_addr (wb_w_addr),
        .wb_w_data (wb_w_data),
        .wb_w_en   (wb_w_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [4:0] a, input logic [31:0] d, input logic en);
        ex_w_addr = a;
        ex_w_data = d;
        ex_w_en   = en;
        #1;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rd1_addr = a1;
        rd2_addr = a2;
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] a, input logic [31:0] d, input logic en);
        chk({tag, "_addr"}, {27'd0, wb_w_addr}, {27'd0, a});
        chk({tag, "_data"}, wb_w_data, d);
        chk({tag, "_en"},   {31'd0, wb_w_en}, {31'd0, en});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rd1_en = 1'b1; rd2_en = 1'b1; rd1_addr = 5'd0; rd2_addr = 5'd0;
        ex_w_addr = 5'd1; ex_w_data = 32'h1234_5678; ex_w_en = 1'b1;
        #1;
        // Reads are forced to 0 while reset is low, even with a matching EX write
        rd(5'd1, 5'd1);
        chk("rst_rd1_forced", rd1_data, 32'h0);
        chk("rst_rd2_forced", rd2_data, 32'h0);
        step();
        chk_wb("rst_wb", 5'd0, 32'h0, 1'b0);
        ex(5'd0, 32'h0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rf_r1", rd1_data, 32'h0);

        // Basic write r3 = F0F0
        rd(5'd3, 5'd3);
        rd2_en = 1'b0;
        ex(5'd3, 32'h0000_F0F0, 1'b1);
        chk("bw_ex_fwd", rd1_data, 32'h0000_F0F0);
        chk("bw_rd2_disabled", rd2_data, 32'h0);
        rd2_en = 1'b1;
        step();
        ex(5'd0, 32'h0, 1'b0);
        chk("bw_mem_fwd", rd1_data, 32'h0000_F0F0);
        chk_wb("bw_wb_c1", 5'd0, 32'h0, 1'b0);
        step();
        chk_wb("bw_wb_c2", 5'd3, 32'h0000_F0F0, 1'b1);
        chk("bw_wb_fwd", rd1_data, 32'h0000_F0F0);
        step();
        chk("bw_rf_c3", rd1_data, 32'h0000_F0F0);
        step();
        chk("bw_rf_c4", rd2_data, 32'h0000_F0F0);
        chk_wb("bw_wb_c4", 5'd0, 32'h0, 1'b0);

        // Forwarding priority on r5
        rd(5'd5, 5'd5);
        ex(5'd5, 32'h11, 1'b1);
        chk("fw_t0_rd1", rd1_data, 32'h11);
        chk("fw_t0_rd2", rd2_data, 32'h11);
        step();
        ex(5'd5, 32'h22, 1'b1);
        chk("fw_t1_rd1", rd1_data, 32'h22);
        chk("fw_t1_rd2", rd2_data, 32'h22);
        step();
        ex(5'd5, 32'h33, 1'b1);
        chk("fw_t2_rd1", rd1_data, 32'h33);
        chk("fw_t2_rd2", rd2_data, 32'h33);
        step();
        ex(5'd0, 32'h0, 1'b0);
        chk("fw_t3_rd1", rd1_data, 32'h33);
        chk("fw_t3_rd2", rd2_data, 32'h33);
        step();
        chk("fw_t4_rd1", rd1_data, 32'h33);
        step();
        chk("fw_t5_rd1", rd1_data, 32'h33);
        chk("fw_t5_rd2", rd2_data, 32'h33);
        step();
        chk("fw_t6_rf", rd1_data, 32'h33);

        // Zero register never reads back a written value
        rd(5'd0, 5'd0);
        ex(5'd0, 32'hDEAD_BEEF, 1'b1);
        chk("z_ex", rd1_data, 32'h0);
        step();
        ex(5'd0, 32'h0, 1'b0);
        chk("z_mem", rd1_data, 32'h0);
        step();
        chk_wb("z_wb", 5'd0, 32'hDEAD_BEEF, 1'b1);
        chk("z_wbstage", rd1_data, 32'h0);
        step();
        chk("z_after", rd2_data, 32'h0);

        // Flush squashes r7 = 77 as it enters MEM
        rd(5'd7, 5'd7);
        ex(5'd7, 32'h77, 1'b1);
        flush = 1'b1;
        chk("fl_ex_fwd", rd1_data, 32'h77);
        step();
        flush = 1'b0;
        ex(5'd0, 32'h0, 1'b0);
        chk("fl_mem", rd1_data, 32'h0);
        step();
        chk_wb("fl_wb", 5'd0, 32'h0, 1'b0);
        chk("fl_wbstage", rd2_data, 32'h0);
        step();
        chk("fl_rf", rd1_data, 32'h0);

        // Stall with r9 = 99 in WB and r10 = A0A0 in MEM
        rd(5'd9, 5'd10);
        ex(5'd9, 32'h99, 1'b1);
        step();
        ex(5'd10, 32'hA0A0, 1'b1);
        step();
        ex(5'd0, 32'h0, 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        chk_wb("st_load", 5'd9, 32'h99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            flush = 1'b0;
            chk_wb("st_hold", 5'd9, 32'h99, 1'b1);
            chk("st_r9", rd1_data, 32'h99);
            chk("st_mem_r10", rd2_data, 32'hA0A0);
        end
        stall = 1'b0;
        ex(5'd9, 32'hAA, 1'b1);
        chk("st_rel_ex_fwd", rd1_data, 32'hAA);
        step();
        ex(5'd0, 32'h0, 1'b0);
        chk_wb("st_rel_c1", 5'd10, 32'hA0A0, 1'b1);
        chk("st_rel_r9_mem", rd1_data, 32'hAA);
        step();
        chk_wb("st_rel_c2", 5'd9, 32'hAA, 1'b1);
        step();
        step();
        chk("st_rf_r9", rd1_data, 32'hAA);
        chk("st_rf_r10", rd2_data, 32'hA0A0);
        rd(5'd3, 5'd5);
        chk("pre_rst_r3", rd1_data, 32'h0000_F0F0);
        chk("pre_rst_r5", rd2_data, 32'h33);

        // Reset clears the preloaded register file
        rst_n = 1'b0;
        step();
        chk_wb("rst2_wb", 5'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        for (int a = 1; a < 32; a++) begin
            rd(a[4:0], 5'(32 - a));
            chk($sformatf("rst2_rd1_r%0d", a), rd1_data, 32'h0);
            chk($sformatf("rst2_rd2_r%0d", 32 - a), rd2_data, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the execute-stage write-back triple (write address, write data, write enable).
- Carries the triple through the MEM and WB pipeline registers and commits it to the 32-entry general register file at WB.
- Serves the decode stage's two operand read ports, forwarding from in-flight writes so back-to-back dependent instructions read correct data.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (2**ADDR_W).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- ex_w_addr  in  ADDR_W  write address from execute stage.
- ex_w_data  in  DATA_W  write data from execute stage.
- ex_w_en  in  1  write enable from execute stage.
- stall  in  1  hold the MEM and WB pipeline registers.
- flush  in  1  squash the instruction entering MEM.
- rd1_en  in  1  read port 1 enable.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data, combinational.
- rd2_en  in  1  read port 2 enable.
- rd2_addr  in  ADDR_W  read port 2 address.
- rd2_data  out  DATA_W  read port 2 data, combinational.
- wb_w_addr  out  ADDR_W  committed write address (WB stage), for trace.
- wb_w_data  out  DATA_W  committed write data (WB stage).
- wb_w_en  out  1  committed write enable (WB stage).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - MEM and WB registers cleared: addr=0, data=0, en=0.
  - All register file entries cleared to 0.
  - wb_w_* outputs = 0.
  - rd1_data and rd2_data forced to 0 combinationally while rst_n=0.
- Pipeline, normal operation:
  - Each edge, the MEM register captures ex_w_*.
  - The WB register captures the MEM register.
  - ex_w_* reaches wb_w_* 2 cycles after being presented.
- stall=1:
  - MEM and WB registers hold their values.
  - The register file write still occurs, but only once per WB-register occupancy. It is suppressed while WB is unchanged: a write-pending flag is set on WB load and cleared on commit.
- flush=1 (not stalled): the MEM register loads en=0, addr=0, data=0; WB advances normally.
- flush and stall both 1: stall has priority; flush is ignored that cycle.
- Commit:
  - At the clock edge, if the WB register's en=1, the write is pending, and its addr!=0, then regfile[addr] <= data.
  - Writes to address 0 are discarded. Register 0 always reads 0.
- Read port n, combinational, evaluated in priority order:
  1. rst_n=0 or rdn_en=0 -> 0.
  2. rdn_addr==0 -> 0.
  3. ex_w_en=1 and ex_w_addr==rdn_addr -> ex_w_data (newest).
  4. MEM en=1 and MEM addr==rdn_addr -> MEM data.
  5. WB en=1 and WB addr==rdn_addr -> WB data (read-during-write bypass).
  6. Otherwise -> regfile[rdn_addr].
- Both ports are independent and may read the same address simultaneously.
- Forwarding compares only entries with en=1; a squashed (flushed) MEM slot never forwards.
- No internal arithmetic; data passes bit-exact.

Test Plan:
- Reset: preload regfile by writes, then assert rst_n=0 for 1 cycle -> wb_w_*=0, and reading r1..r31 returns 0 afterwards.
- Basic write: ex_w_addr=3, data=0x0000_F0F0, en=1 for one cycle; read r3 from cycle 3 on -> wb_w_* shows the write 2 cycles later, and rd1_data=0x0000_F0F0 persists with ex_w_en=0.
- Forwarding priority: write r5=0x11 at t, 0x22 at t+1, 0x33 at t+2; read r5 on both ports each cycle -> t: 0x11; t+1: 0x22; t+2: 0x33; t+3 onward: 0x33.
- Zero register: write r0=0xDEAD_BEEF with en=1 -> rd1_data for r0=0 on every cycle, including while the write is in EX, MEM and WB.
- Flush: present r7=0x77 with flush=1 in the same cycle -> MEM en=0, r7 never written, no forwarding of 0x77 after EX.
- Stall hold: r9=0x99 in WB, stall=1 for 4 cycles -> wb_w_* constant, one regfile write, r9=0x99. Then release stall with new data r9=0xAA behind it -> r9=0xAA after 2 cycles.
